// File: rtl/can_filter_pkg.sv
// ---------------------------------------------------------------------------
// can_filter_pkg
// Shared types and constants for the CAN acceptance filter bank.
//   filter_entry_t : one programmable filter entry (enable, IDE type,
//                    29-bit acceptance code, 29-bit acceptance mask)
//   state_t        : lookup FSM states
//   STD_ID_MASK    : identifier bits that take part in a standard-frame match
//   EXT_ID_MASK    : identifier bits that take part in an extended-frame match
// ---------------------------------------------------------------------------
package can_filter_pkg;

  localparam logic [28:0] STD_ID_MASK = 29'h7FF;
  localparam logic [28:0] EXT_ID_MASK = 29'h1FFFFFFF;

  typedef struct packed {
    logic        en;
    logic        ide;
    logic [28:0] code;
    logic [28:0] mask;
  } filter_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_t;

endpackage

// File: rtl/can_filter_match.sv
// ---------------------------------------------------------------------------
// can_filter_match
// Combinational comparator for a single filter entry against one identifier.
// Ports:
//   entry   in  filter entry under test
//   req_ide in  frame format of the identifier (1 = extended)
//   req_id  in  29-bit identifier, standard ids sit in [10:0]
//   hit     out entry is enabled, of the same frame type and matches on
//               every bit its mask selects
// ---------------------------------------------------------------------------
module can_filter_match
  import can_filter_pkg::*;
(
  input  filter_entry_t entry,
  input  logic          req_ide,
  input  logic [28:0]   req_id,
  output logic          hit
);

  logic [28:0] w_widthMask;

  // A standard frame only carries 11 identifier bits, so code/mask bits
  // above [10] must not influence the result for standard entries.
  always_comb begin
    w_widthMask = req_ide ? EXT_ID_MASK : STD_ID_MASK;
    hit = entry.en
       && (entry.ide == req_ide)
       && (((req_id ^ entry.code) & entry.mask & w_widthMask) == 29'd0);
  end

endmodule

// File: rtl/can_filter_bank.sv
// ---------------------------------------------------------------------------
// can_filter_bank
// Multi-entry CAN acceptance filter. Entries are scanned one per cycle for
// each received identifier; the lowest-index matching entry is reported.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_we/cfg_idx/cfg_code/cfg_mask/cfg_ide/cfg_en
//                            write one filter entry (taken only when cfg_ready)
//   cfg_ready                configuration write accepted this cycle
//   req_valid/req_ready      identifier lookup handshake
//   req_ide/req_id           frame format and identifier of the lookup
//   resp_valid/resp_ready    lookup result handshake
//   resp_accept              some enabled entry matched
//   resp_hit_idx             lowest matching entry index, 0 on reject
// Optional build macro CAN_FILTER_STATS_EN adds:
//   stat_clr                 clear both statistic counters
//   stat_accept_cnt          saturating count of accepted lookups
//   stat_reject_cnt          saturating count of rejected lookups
// ---------------------------------------------------------------------------
module can_filter_bank
  import can_filter_pkg::*;
#(
  parameter int NUM_FILTERS = 8,
  parameter int IDX_W       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [28:0]      cfg_code,
  input  logic [28:0]      cfg_mask,
  input  logic             cfg_ide,
  input  logic             cfg_en,
  output logic             cfg_ready,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_ide,
  input  logic [28:0]      req_id,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_accept,
`ifdef CAN_FILTER_STATS_EN
  input  logic             stat_clr,
  output logic [15:0]      stat_accept_cnt,
  output logic [15:0]      stat_reject_cnt,
`endif
  output logic [IDX_W-1:0] resp_hit_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

  filter_entry_t    r_entries [NUM_FILTERS];
  state_t           r_state;
  state_t           w_nextState;
  logic [IDX_W-1:0] r_scanIdx;
  logic             r_reqIde;
  logic [28:0]      r_reqId;
  logic             r_respAccept;
  logic [IDX_W-1:0] r_respHitIdx;
  filter_entry_t    w_selEntry;
  logic             w_hit;
  logic             w_lastIdx;
  logic             w_cfgWrite;

  assign w_selEntry   = r_entries[r_scanIdx];
  assign w_lastIdx    = (r_scanIdx == LAST_IDX);
  assign w_cfgWrite   = cfg_we && cfg_ready && (int'(cfg_idx) < NUM_FILTERS);
  assign resp_accept  = r_respAccept;
  assign resp_hit_idx = r_respHitIdx;

  // Only the entry currently pointed at by the scan index is compared.
  can_filter_match u_match (
    .entry   (w_selEntry),
    .req_ide (r_reqIde),
    .req_id  (r_reqId),
    .hit     (w_hit)
  );

  // State register for the lookup FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs. In IDLE a configuration write wins
  // over a lookup request presented in the same cycle.
  always_comb begin
    w_nextState = r_state;
    cfg_ready   = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        cfg_ready = 1'b1;
        req_ready = !cfg_we;
        if (req_valid && !cfg_we) begin
          w_nextState = SCAN;
        end
      end
      SCAN: begin
        if (w_hit || w_lastIdx) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Filter entry storage; out-of-range indices are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        r_entries[k] <= '0;
      end
    end else if (w_cfgWrite) begin
      r_entries[cfg_idx] <= '{en: cfg_en, ide: cfg_ide, code: cfg_code, mask: cfg_mask};
    end
  end

  // Request latch, scan index and result registers. The first hit ends the
  // scan, which is what makes the lowest matching index win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scanIdx    <= '0;
      r_reqIde     <= 1'b0;
      r_reqId      <= '0;
      r_respAccept <= 1'b0;
      r_respHitIdx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && req_ready) begin
            r_reqIde  <= req_ide;
            r_reqId   <= req_id;
            r_scanIdx <= '0;
          end
        end
        SCAN: begin
          if (w_hit) begin
            r_respAccept <= 1'b1;
            r_respHitIdx <= r_scanIdx;
          end else if (w_lastIdx) begin
            r_respAccept <= 1'b0;
            r_respHitIdx <= '0;
          end else begin
            r_scanIdx <= r_scanIdx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CAN_FILTER_STATS_EN
  logic        w_respFire;
  logic [15:0] r_acceptCnt;
  logic [15:0] r_rejectCnt;

  assign w_respFire      = resp_valid && resp_ready;
  assign stat_accept_cnt = r_acceptCnt;
  assign stat_reject_cnt = r_rejectCnt;

  // Saturating statistics; a clear overrides a coincident response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acceptCnt <= '0;
      r_rejectCnt <= '0;
    end else if (stat_clr) begin
      r_acceptCnt <= '0;
      r_rejectCnt <= '0;
    end else if (w_respFire) begin
      if (r_respAccept) begin
        if (r_acceptCnt != 16'hFFFF) begin
          r_acceptCnt <= r_acceptCnt + 16'd1;
        end
      end else begin
        if (r_rejectCnt != 16'hFFFF) begin
          r_rejectCnt <= r_rejectCnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/can_filter_bank.md
Name: can_filter_bank

Overview:
Multi-entry CAN acceptance filter bank, the parametrised successor to the single code/mask filter. Holds NUM_FILTERS programmable entries, each with a code, mask, IDE type and enable bit. Scans the entries sequentially, one per cycle, for each received identifier. Returns accept/reject and the lowest-index matching entry over a valid/ready handshake. Sits between the CAN RX frame decoder and the RX FIFO write path; the register block programs it.

Parameters:
NUM_FILTERS, 8, number of filter entries (1..64)
IDX_W, (NUM_FILTERS>1 ? $clog2(NUM_FILTERS) : 1), entry index width (derived; do not override)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  write one filter entry
cfg_idx  in  IDX_W  entry index to write
cfg_code  in  29  acceptance code; standard entries use [10:0]
cfg_mask  in  29  acceptance mask; 1 = compare bit, 0 = don't care
cfg_ide  in  1  entry matches extended (1) or standard (0) frames
cfg_en  in  1  entry enable
cfg_ready  out  1  config write accepted this cycle
req_valid  in  1  identifier lookup request
req_ready  out  1  bank can accept a request
req_ide  in  1  frame format of request
req_id  in  29  {id_std, id_ext} for extended; {18'b0, id_std} for standard
resp_valid  out  1  lookup result valid
resp_ready  in  1  consumer takes result
resp_accept  out  1  1 = some enabled entry matched
resp_hit_idx  out  IDX_W  lowest matching entry index; 0 on reject

Behaviour:
- Reset (asynchronous, rst=1): FSM to IDLE; all entries have en=0 and code, mask, ide = 0; resp_valid=0, resp_accept=0, resp_hit_idx=0, scan index=0. A reset asserted mid-scan or mid-response aborts the operation with no response.
- Entry k matches when all of these hold:
  - en[k]=1
  - ide[k]==latched req_ide
  - ((id ^ code[k]) & mask[k] & W)==0, where W=29'h7FF for standard and 29'h1FFFFFFF for extended; code/mask bits [28:11] are ignored for standard.
- FSM states:
  - IDLE: cfg_ready=1, req_ready=!cfg_we. A cfg write has priority over a request in the same cycle. req_valid&&req_ready latches req_ide/req_id, sets scan index=0, goes to SCAN.
  - SCAN: evaluate entry[scan index] each cycle. On match, latch resp_accept=1 and resp_hit_idx=index, go to RESP. On no match at index NUM_FILTERS-1, latch resp_accept=0 and resp_hit_idx=0, go to RESP. Otherwise increment the index. cfg_ready=0 and req_ready=0 in SCAN.
  - RESP: resp_valid=1. Outputs hold stable until resp_ready. On resp_valid&&resp_ready, go to IDLE. No back-to-back request acceptance in the handoff cycle. cfg_ready=0 and req_ready=0 in RESP.
- Latency, with the handshake at cycle T:
  - a match at entry k gives resp_valid from T+2+k;
  - a reject gives resp_valid from T+1+NUM_FILTERS.
- cfg_we with cfg_ready=0 is ignored; the writer must hold it. cfg_idx >= NUM_FILTERS is ignored.
- Duplicate matching entries report the lowest index.
- NUM_FILTERS=1: the scan index never increments; reject latency is 2.

Optional Feature:
CAN_FILTER_STATS_EN
- Defined: adds outputs stat_accept_cnt[15:0] and stat_reject_cnt[15:0] plus input stat_clr.
- Each counter increments on the response handshake according to resp_accept and saturates at 16'hFFFF.
- stat_clr zeroes both counters. stat_clr coincident with a handshake leaves the counter at 0. Both counters reset to 0.
- Undefined: these ports and the counters do not exist; all other behaviour is identical.

Decomposition:
- Package can_filter_pkg holds:
  - filter_entry_t struct {en, ide, code[28:0], mask[28:0]};
  - state enum {IDLE, SCAN, RESP};
  - constants STD_ID_MASK=29'h7FF and EXT_ID_MASK=29'h1FFFFFFF.
- One sub-module can_filter_match: combinational single-entry comparator (entry, req_ide, req_id -> hit), instantiated once on the entry selected by the scan index.

Test Plan:
1. Reset, then request std id 11'h123 -> resp_valid at T+1+8, resp_accept=0, resp_hit_idx=0.
2. Entry 3 = {en=1, ide=0, code=11'h120, mask=11'h7F0}; request std 11'h12F -> accept=1, idx=3, resp_valid at T+5. Request 11'h13F -> reject.
3. Entries 2 and 5 both ext {code=29'h1ABCDE00, mask=29'h1FFFFF00, ide=1}; request ext 29'h1ABCDE42 -> idx=2. The same id sent as standard (ide=0) -> reject.
4. Hold resp_ready=0 for 10 cycles -> resp_valid/accept/idx stable, req_ready=0. cfg_we during that time is not taken (cfg_ready=0).
5. cfg_we and req_valid in the same IDLE cycle -> write committed, req_ready=0, request accepted the next cycle and sees the new entry. Assert rst mid-SCAN -> resp_valid=0 and all entries disabled.
6. With CAN_FILTER_STATS_EN: 3 accepts and 2 rejects -> counters 3 and 2. stat_clr -> 0/0. Preload the accept counter near 16'hFFFF -> saturates.
